// File: rtl/rand_sample_buffer.sv
// Sampling FIFO behind the LFSR range generator: owns the generator's range,
// captures its output at a fixed pace and serves samples first-word-fall-through.
module rand_sample_buffer #(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 8,
  parameter int SAMPLE_DIV = 4,
  parameter int SETTLE     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           rand_in,
  output logic [WIDTH-1:0]           range_min,
  output logic [WIDTH-1:0]           range_max,
  input  logic                       cfg_we,
  input  logic [WIDTH-1:0]           cfg_min,
  input  logic [WIDTH-1:0]           cfg_max,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE+1) : 1;

  localparam logic [AW-1:0] PTR_ONE     = AW'(1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_FULL    = CW'(DEPTH);
  localparam logic [DW-1:0] DIV_ONE     = DW'(1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(SAMPLE_DIV-1);
  localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_out_data;
  logic             r_overflow;
  logic [WIDTH-1:0] r_range_min;
  logic [WIDTH-1:0] r_range_max;
  logic [DW-1:0]    r_div;
  logic [SW-1:0]    r_settle;

  logic             w_opp;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [AW-1:0]    w_rd_ptr_nxt;
  logic [WIDTH-1:0] w_head_nxt;
  logic [DW-1:0]    w_div_nxt;

  // Handshake: a sample transfers on every edge where out_valid and out_ready
  // are both high; out_valid never depends on out_ready, and a transfer in a
  // cfg_we cycle is consumed but its data is discarded by the flush.
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_opp     = (r_div == DIV_LAST) && (r_settle == '0);
  assign w_push    = w_opp && ((r_count != CNT_FULL) || w_pop);
  assign w_drop    = w_opp && !w_push;
  assign w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + DIV_ONE;

  assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + PTR_ONE : r_rd_ptr;
  // The new head is the incoming sample whenever it lands in the head slot.
  assign w_head_nxt = (w_push && (r_wr_ptr == w_rd_ptr_nxt)) ? rand_in
                                                             : r_mem[w_rd_ptr_nxt];

  always_ff @(posedge clk) begin
    if (w_push && !cfg_we) begin
      r_mem[r_wr_ptr] <= rand_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_out_data  <= '0;
      r_overflow  <= 1'b0;
      r_range_min <= '0;
      r_range_max <= '1;
      r_div       <= '0;
      r_settle    <= SETTLE_INIT;
    end else if (cfg_we) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_out_data  <= '0;
      r_overflow  <= 1'b0;
      r_range_min <= cfg_min;
      r_range_max <= cfg_max;
      r_div       <= '0;
      r_settle    <= SETTLE_INIT;
    end else begin
      r_div      <= w_div_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_out_data <= w_head_nxt;
      if (r_settle != '0) begin
        r_settle <= r_settle - SETTLE_ONE;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign range_min = r_range_min;
  assign range_max = r_range_max;
  assign out_data  = r_out_data;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_rand_sample_buffer.sv
// Directed bench for rand_sample_buffer: a queue model of the sampling rules
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_rand_sample_buffer;

  localparam int W     = 4;
  localparam int DEPTH = 8;
  localparam int SDIV  = 4;
  localparam int SETL  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         cfg_we = 1'b0;
  logic [W-1:0] cfg_min = '0;
  logic [W-1:0] cfg_max = '0;
  logic         out_ready = 1'b0;
  logic [W-1:0] rand_in;
  logic [W-1:0] range_min, range_max, out_data;
  logic         out_valid, overflow;
  logic [$clog2(DEPTH+1)-1:0] count;

  // rand_in source: 0 = directed constant, 1 = ramp, 2 = generator model
  int           src = 0;
  logic [W-1:0] const_v = 4'd5;
  logic [W-1:0] ramp_q;
  logic [W-1:0] gen_q;
  logic [7:0]   lfsr;

  assign rand_in = (src == 2) ? gen_q : (src == 1) ? ramp_q : const_v;

  rand_sample_buffer #(.WIDTH(W), .DEPTH(DEPTH), .SAMPLE_DIV(SDIV), .SETTLE(SETL)) dut (
    .clk(clk), .reset(reset), .rand_in(rand_in),
    .range_min(range_min), .range_max(range_max),
    .cfg_we(cfg_we), .cfg_min(cfg_min), .cfg_max(cfg_max),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .overflow(overflow)
  );

  // Inputs and DUT outputs as seen at the negedge, used at the following posedge.
  logic         s_cfg = 1'b0, s_ready = 1'b0;
  logic [W-1:0] s_rand = '0, s_cmin = '0, s_cmax = '0;
  logic [W-1:0] s_rmin = '0, s_rmax = '1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  logic [W-1:0] exp_q[$];
  logic         m_ovf = 1'b0;
  logic [W-1:0] m_min = '0;
  logic [W-1:0] m_max = '1;
  int           m_k   = 0;   // edges since reset release or last config write
  logic [W-1:0] pops[$];

  // Model: capture on edges k with k mod SAMPLE_DIV == SAMPLE_DIV-1 once k >= SETTLE.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete(); m_ovf = 1'b0; m_min = '0; m_max = '1; m_k = 0;
    end else if (s_cfg) begin
      exp_q.delete(); m_ovf = 1'b0; m_min = s_cmin; m_max = s_cmax; m_k = 0;
    end else begin
      if (exp_q.size() > 0 && s_ready) void'(exp_q.pop_front());
      if ((m_k % SDIV == SDIV-1) && (m_k >= SETL)) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(s_rand);
        else m_ovf = 1'b1;
      end
      m_k++;
    end
  end

  always @(negedge clk) begin
    chk("count", int'(count), exp_q.size());
    chk("out_valid", int'(out_valid), (exp_q.size() != 0) ? 1 : 0);
    if (exp_q.size() != 0) chk("out_data", int'(out_data), int'(exp_q[0]));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("range_min", int'(range_min), int'(m_min));
    chk("range_max", int'(range_max), int'(m_max));
    if (!reset && !cfg_we && out_valid && out_ready) pops.push_back(out_data);
    s_cfg = cfg_we; s_ready = out_ready; s_rand = rand_in;
    s_cmin = cfg_min; s_cmax = cfg_max; s_rmin = range_min; s_rmax = range_max;
  end

  // ---------------- stimulus sources ----------------
  always @(posedge clk or posedge reset) begin
    if (reset) ramp_q <= '0;
    else if (s_cfg) ramp_q <= '0;
    else ramp_q <= ramp_q + 4'd1;
  end

  // Behavioural stand-in for random_gen: registered min + lfsr mod span.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr  <= 8'hA5;
      gen_q <= '0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (s_rmax > s_rmin) gen_q <= W'(int'(s_rmin) + (int'(lfsr) % (int'(s_rmax) - int'(s_rmin) + 1)));
      else gen_q <= s_rmin;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [W-1:0] mn, input logic [W-1:0] mx);
    cfg_we = 1'b1; cfg_min = mn; cfg_max = mx;
    tick(1);
    cfg_we = 1'b0;
  endtask

  int exp_ramp[5] = '{3, 7, 11, 15, 3};
  int bad;

  initial begin
    tick(2);
    reset = 1'b0;

    // Constant 5, no consumer: fill to DEPTH, then overflow.
    tick(4);
    chk("first_capture_valid", int'(out_valid), 1);
    chk("first_capture_count", int'(count), 1);
    tick(32);
    chk("full_count", int'(count), 8);
    chk("full_overflow", int'(overflow), 1);
    chk("full_out_data", int'(out_data), 5);

    // Drain three, then reconfigure with count=5 and overflow set.
    out_ready = 1'b1;
    tick(3);
    chk("drained_count", int'(count), 5);
    cfg_write(4'd2, 4'd9);
    out_ready = 1'b0;
    chk("cfg_range_min", int'(range_min), 2);
    chk("cfg_range_max", int'(range_max), 9);
    chk("cfg_count", int'(count), 0);
    chk("cfg_out_valid", int'(out_valid), 0);
    chk("cfg_overflow", int'(overflow), 0);
    tick(3);
    chk("settle_no_capture", int'(count), 0);
    tick(1);
    chk("settle_first_capture", int'(count), 1);
    chk("settle_first_data", int'(out_data), 5);

    // Ramp input with a consumer that is always ready.
    src = 1; out_ready = 1'b1;
    pops.delete();
    cfg_write(4'd0, 4'd15);
    tick(21);
    chk("ramp_pop_count", pops.size(), 5);
    for (int i = 0; i < 5 && i < pops.size(); i++) chk("ramp_pop_value", int'(pops[i]), exp_ramp[i]);
    chk("ramp_overflow", int'(overflow), 0);

    // Fill with 1..8, then push+pop at full across the pointer wrap.
    src = 0; out_ready = 1'b0;
    cfg_write(4'd0, 4'd15);
    for (int i = 0; i < 8; i++) begin
      const_v = W'(i + 1);
      tick(4);
    end
    chk("fill_count", int'(count), 8);
    chk("fill_head", int'(out_data), 1);
    const_v = 4'd9;
    tick(3);
    out_ready = 1'b1;
    pops.delete();
    tick(1);
    chk("pushpop_count", int'(count), 8);
    chk("pushpop_overflow", int'(overflow), 0);
    const_v = 4'd10;
    tick(9);
    out_ready = 1'b0;
    chk("wrap_pop_count", (pops.size() >= 9) ? 9 : pops.size(), 9);
    for (int i = 0; i < 9 && i < pops.size(); i++) chk("wrap_order", int'(pops[i]), i + 1);

    // Asynchronous reset mid-stream with a handshake pending.
    const_v = 4'd7;
    cfg_write(4'd1, 4'd12);
    tick(12);
    chk("pre_reset_count", int'(count), 3);
    out_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_out_data", int'(out_data), 0);
    chk("async_overflow", int'(overflow), 0);
    chk("async_range_min", int'(range_min), 0);
    chk("async_range_max", int'(range_max), 15);
    tick(2);
    reset = 1'b0;

    // Generator in the loop with range 3..6.
    src = 2; out_ready = 1'b1;
    cfg_write(4'd3, 4'd6);
    pops.delete();
    for (int c = 0; c < 400 && pops.size() < 64; c++) tick(1);
    chk("gen_pop_count", (pops.size() >= 64) ? 64 : pops.size(), 64);
    bad = 0;
    for (int i = 0; i < 64 && i < pops.size(); i++) if (pops[i] < 4'd3 || pops[i] > 4'd6) bad++;
    chk("gen_out_of_range", bad, 0);
    chk("gen_range_min", int'(range_min), 3);
    chk("gen_range_max", int'(range_max), 6);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rand_sample_buffer.md
Name: rand_sample_buffer

Overview:
- Downstream consumer of the LFSR range generator (random_gen).
- Drives the generator's min/max range inputs from a config write port.
- Samples the generator's registered output at a programmable pace and stores the samples in a small first-word-fall-through FIFO.
- Serves samples to game logic / CPU over a valid/ready handshake; flushes stale samples whenever the range changes.

Parameters:
- WIDTH, 4, sample width; must match the generator's WIDTH.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- SAMPLE_DIV, 4, clocks between capture opportunities; >= 1.
- SETTLE, 2, clocks to ignore rand_in after reset or config change; covers the generator's one-cycle output register plus margin.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- rand_in  in  WIDTH  random_out of the generator.
- range_min  out  WIDTH  drives generator min.
- range_max  out  WIDTH  drives generator max.
- cfg_we  in  1  one-cycle strobe that loads cfg_min/cfg_max.
- cfg_min  in  WIDTH  new range minimum.
- cfg_max  in  WIDTH  new range maximum.
- out_data  out  WIDTH  FIFO head; valid only when out_valid=1.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky flag: a capture was dropped because the FIFO was full.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - range_min=0, range_max={WIDTH{1'b1}}.
  - FIFO empty: count=0, out_valid=0, out_data=0, rd/wr pointers=0.
  - overflow=0, divider=0, settle counter=SETTLE.
- Settle counter:
  - Decrements each clock while nonzero.
  - While nonzero, no capture occurs; the divider still runs.
- Divider:
  - Counts 0..SAMPLE_DIV-1, then wraps.
  - Capture opportunity on the cycle the divider equals SAMPLE_DIV-1 and settle is 0.
  - SAMPLE_DIV=1 gives an opportunity every cycle.
- Capture: on an opportunity, rand_in is written at the FIFO tail at that clock edge.
  - Accepted if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
  - Otherwise dropped, and overflow is set to 1.
- Pop: occurs when out_valid & out_ready at the clock edge.
  - Head advances; out_data shows the next entry in the following cycle (FWFT).
  - out_ready while empty has no effect.
- count: incremented on push-only, decremented on pop-only, unchanged on push+pop.
  - Never exceeds DEPTH; never underflows.
- Pointers: wrap modulo DEPTH.
- Config write (cfg_we=1 at an edge):
  - range_min/range_max load cfg_min/cfg_max.
  - FIFO flushes: count=0, pointers=0.
  - overflow clears; divider resets to 0; settle reloads SETTLE.
  - Takes priority over any capture or pop in the same cycle. A handshake in that cycle counts as consumed from the consumer's view, but the data is discarded.
- Invalid range (cfg_max<=cfg_min): loaded unchanged, with no checking. The generator then emits min; the buffer stores those values normally.
- Latency:
  - First capture at the earliest opportunity with settle=0. After reset with SAMPLE_DIV=4 and SETTLE=2, that is the divider=3 cycle.
  - out_valid rises the cycle after the capturing edge.
- Outputs: all registered except out_valid, which is derived from registered count. No combinational path from out_ready to any output.

Test Plan:
- Reset release, rand_in held at 5, out_ready=0:
  - captures at divider=3 edges (clock cycles 4, 8, …).
  - out_valid=1 after the first capture.
  - count reaches 8 after 8 captures, stays at 8.
  - the next opportunity sets overflow=1; out_data stays 5.
- Ramp rand_in 0,1,2… each cycle, SAMPLE_DIV=4, out_ready=1 continuously: popped sequence is 3,7,11,15,3,… (4-bit wrap); count toggles 0/1; overflow stays 0.
- FIFO full (count=8) with out_ready=1 on a capture cycle:
  - simultaneous push+pop accepted; count stays 8; overflow stays 0.
  - order preserved across the pointer wrap.
- cfg_we with cfg_min=2, cfg_max=9 while count=5 and overflow=1:
  - next cycle range_min=2, range_max=9, count=0, out_valid=0, overflow=0.
  - no capture for 2 clocks; first capture on the divider=3 cycle after settle.
- Assert reset mid-stream with count=3 and out_valid&out_ready high: all outputs return to reset values immediately (async), and range_max=15.
- Connect to the real generator with range 3..6: after 64 pops, every sample lies in [3,6].
